// File: rtl/control_mode_pkg.sv
// Shared types and helpers for the control-mode selector.
// Mode codes, the size of the mode ring, and small decode helpers
// used by the state register and the output enables.
package control_mode_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'b00,
    KEYBOARD   = 2'b01,
    ULTRASONIC = 2'b10
  } mode_t;

  localparam int MODE_COUNT = 3;

  // Returns {ultrasonic_enable, keyboard_enable} for a mode; idle and
  // illegal codes enable neither source.
  function automatic logic [1:0] mode_enables(input mode_t mode);
    logic [1:0] en;
    case (mode)
      KEYBOARD:   en = 2'b01;
      ULTRASONIC: en = 2'b10;
      default:    en = 2'b00;
    endcase
    return en;
  endfunction

  // A code is legal when it indexes one of the ring positions.
  function automatic logic mode_legal(input logic [1:0] code);
    return (code < 2'(MODE_COUNT));
  endfunction

endpackage

// File: rtl/button_conditioner.sv
// Pushbutton conditioner: multi-flop synchronizer, optional debouncer,
// and a single-cycle rising-edge press pulse.
// Optional debouncer is built when CONTROL_MODE_DEBOUNCE_EN is defined.
module button_conditioner
  import control_mode_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic button,
  output logic press
);

  // Fewer than two flops cannot resolve metastability, so clamp.
  localparam int STAGES = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  logic [STAGES-1:0] sync_r;
  logic              level_s;
  logic              prev_r;

  // Shift the raw button level through the synchronizer chain.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_r <= {STAGES{1'b0}};
    end else begin
      sync_r <= {sync_r[STAGES-2:0], button};
    end
  end

`ifdef CONTROL_MODE_DEBOUNCE_EN
  localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] cnt_r;
  logic             db_r;

  // Flip the debounced level only after the synced level has disagreed
  // with it for DEBOUNCE_CYCLES consecutive cycles; agreement restarts.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r <= {CNT_W{1'b0}};
      db_r  <= 1'b0;
    end else if (sync_r[STAGES-1] == db_r) begin
      cnt_r <= {CNT_W{1'b0}};
      db_r  <= db_r;
    end else if (cnt_r == CNT_LAST) begin
      cnt_r <= {CNT_W{1'b0}};
      db_r  <= sync_r[STAGES-1];
    end else begin
      cnt_r <= cnt_r + CNT_W'(1);
      db_r  <= db_r;
    end
  end

  assign level_s = db_r;
`else
  logic unused_debounce_cfg_s;

  assign level_s               = sync_r[STAGES-1];
  assign unused_debounce_cfg_s = ^DEBOUNCE_CYCLES;
`endif

  // Remember the previous conditioned level for edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_r <= 1'b0;
    end else begin
      prev_r <= level_s;
    end
  end

  // One pulse per low-to-high transition, however long the level is held.
  assign press = level_s & ~prev_r;

endmodule

// File: rtl/control_mode_fsm.sv
// Control-source selector: right/left presses step a three-position
// mode ring (IDLE, KEYBOARD, ULTRASONIC) forward/backward, and the
// registered one-hot enables follow the mode on the same edge.
// Build option: CONTROL_MODE_DEBOUNCE_EN adds a debouncer per button.
module control_mode_fsm
  import control_mode_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       right,
  input  logic       left,
  output logic [1:0] state,
  output logic       keyboardControlled,
  output logic       ultrasonicControlled
);

  mode_t state_r;
  mode_t next_s;
  logic  kb_r;
  logic  us_r;
  logic  right_press_s;
  logic  left_press_s;
  logic  fwd_s;
  logic  bwd_s;

  button_conditioner #(
    .SYNC_STAGES     (SYNC_STAGES),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_right (
    .clk    (clk),
    .reset  (reset),
    .button (right),
    .press  (right_press_s)
  );

  button_conditioner #(
    .SYNC_STAGES     (SYNC_STAGES),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_left (
    .clk    (clk),
    .reset  (reset),
    .button (left),
    .press  (left_press_s)
  );

  // Simultaneous presses cancel; a release never counts as a press.
  assign fwd_s = right_press_s & ~left_press_s;
  assign bwd_s = left_press_s & ~right_press_s;

  // Next mode: step the ring on a single press, recover illegal codes.
  always_comb begin
    next_s = state_r;
    if (!mode_legal(state_r)) begin
      next_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (fwd_s)      next_s = KEYBOARD;
          else if (bwd_s) next_s = ULTRASONIC;
          else            next_s = IDLE;
        end
        KEYBOARD: begin
          if (fwd_s)      next_s = ULTRASONIC;
          else if (bwd_s) next_s = IDLE;
          else            next_s = KEYBOARD;
        end
        ULTRASONIC: begin
          if (fwd_s)      next_s = IDLE;
          else if (bwd_s) next_s = KEYBOARD;
          else            next_s = ULTRASONIC;
        end
        default: next_s = IDLE;
      endcase
    end
  end

  // Mode register and its enables, decoded from the next mode so both
  // update on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
      kb_r    <= 1'b0;
      us_r    <= 1'b0;
    end else begin
      state_r      <= next_s;
      {us_r, kb_r} <= mode_enables(next_s);
    end
  end

  assign state                = state_r;
  assign keyboardControlled   = kb_r;
  assign ultrasonicControlled = us_r;

endmodule

// File: tb/tb_control_mode_fsm.sv
// Scoreboard bench for control_mode_fsm. Expected modes are queued with
// the cycle they are due when stimulus is driven, then compared after
// each rising edge. Define CONTROL_MODE_DEBOUNCE_EN to run the debounce set.
module tb_control_mode_fsm;
  import control_mode_pkg::*;

  typedef struct {
    string      tag;
    int         due;
    logic [1:0] st;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       right = 1'b0;
  logic       left = 1'b0;
  logic [1:0] state;
  logic       keyboardControlled;
  logic       ultrasonicControlled;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];

  control_mode_fsm dut (
    .clk                  (clk),
    .reset                (reset),
    .right                (right),
    .left                 (left),
    .state                (state),
    .keyboardControlled   (keyboardControlled),
    .ultrasonicControlled (ultrasonicControlled)
  );

  always #5 clk = ~clk;

  // Rising-edge counter used to time scoreboard entries.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Queue an expected mode due 'edges' rising edges from now.
  task automatic expect_at(input string tag, input int edges, input logic [1:0] st);
    exp_t e;
    e.tag = tag;
    e.due = cyc + edges;
    e.st  = st;
    sb_q.push_back(e);
  endtask

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Compare every due entry shortly after each rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
        e = sb_q.pop_front();
        check_eq({e.tag, ".state"}, {30'd0, state}, {30'd0, e.st});
        check_eq({e.tag, ".kb"}, {31'd0, keyboardControlled}, {31'd0, (e.st == 2'd1)});
        check_eq({e.tag, ".us"}, {31'd0, ultrasonicControlled}, {31'd0, (e.st == 2'd2)});
      end
    end
  end

  // Hold a button pattern for 'len' cycles expecting a step from 'from'
  // to 'to' exactly 'lat' edges after it is applied.
  task automatic hold(input string tag, input logic r, input logic l, input int len,
                      input int lat, input logic [1:0] from, input logic [1:0] to);
    right = r;
    left  = l;
    for (int i = 1; i <= len; i++) expect_at(tag, i, (i < lat) ? from : to);
    wait_neg(len);
  endtask

  task automatic run_default_tests();
    // Pulses of 4 high / 4 low stepping right three times.
    hold("pulse1", 1'b1, 1'b0, 4, 3, 2'd0, 2'd1);
    hold("pulse1_lo", 1'b0, 1'b0, 4, 1, 2'd1, 2'd1);
    hold("pulse2", 1'b1, 1'b0, 4, 3, 2'd1, 2'd2);
    hold("pulse2_lo", 1'b0, 1'b0, 4, 1, 2'd2, 2'd2);
    hold("pulse3", 1'b1, 1'b0, 4, 3, 2'd2, 2'd0);
    hold("pulse3_lo", 1'b0, 1'b0, 4, 1, 2'd0, 2'd0);
    hold("to_kb", 1'b1, 1'b0, 4, 3, 2'd0, 2'd1);
    hold("to_kb_lo", 1'b0, 1'b0, 4, 1, 2'd1, 2'd1);
    // Both buttons rising together cancel out.
    hold("both", 1'b1, 1'b1, 6, 1, 2'd1, 2'd1);
    hold("both_lo", 1'b0, 1'b0, 4, 1, 2'd1, 2'd1);
    // Reset lands on the press edge, button held through reset.
    right = 1'b1;
    expect_at("rst_press", 1, 2'd1);
    expect_at("rst_press", 2, 2'd1);
    for (int i = 3; i <= 6; i++) expect_at("rst_press", i, 2'd0);
    for (int i = 7; i <= 10; i++) expect_at("held_rst", i, 2'd1);
    wait_neg(2);
    reset = 1'b1;
    wait_neg(2);
    reset = 1'b0;
    wait_neg(6);
    hold("held_rst_lo", 1'b0, 1'b0, 4, 1, 2'd1, 2'd1);
    // Illegal code recovers to IDLE on the next edge, even with a press.
    right = 1'b1;
    wait_neg(2);
    force dut.state_r = mode_t'(2'b11);
    #1;
    release dut.state_r;
    expect_at("illegal", 1, 2'd0);
    wait_neg(1);
    hold("illegal_lo", 1'b0, 1'b0, 4, 1, 2'd0, 2'd0);
  endtask

  task automatic run_debounce_tests();
    hold("glitch", 1'b1, 1'b0, 5, 99, 2'd0, 2'd0);
    hold("glitch_lo", 1'b0, 1'b0, 30, 99, 2'd0, 2'd0);
    hold("db_press", 1'b1, 1'b0, 20, 19, 2'd0, 2'd1);
    hold("db_press_lo", 1'b0, 1'b0, 40, 99, 2'd1, 2'd1);
  endtask

  // Main stimulus sequence.
  initial begin
    wait_neg(1);
    expect_at("reset", 1, 2'd0);
    wait_neg(4);
    reset = 1'b0;
    hold("idle_hold", 1'b0, 1'b0, 20, 99, 2'd0, 2'd0);
`ifdef CONTROL_MODE_DEBOUNCE_EN
    run_debounce_tests();
`else
    hold("left_hold", 1'b0, 1'b1, 20, 3, 2'd0, 2'd2);
    // Left releases while right rises: only right acts.
    hold("right_hold", 1'b1, 1'b0, 20, 3, 2'd2, 2'd0);
    hold("right_rel", 1'b0, 1'b0, 4, 1, 2'd0, 2'd0);
    run_default_tests();
`endif
    wait_neg(2);
    check_eq("sb_drain", sb_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Watchdog against a stuck run.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
